req_priority_arbiter: RTL and testbench

//  - Shares one resource between N requesters using a registered req/gnt handshake.
//  - A grant is held for as long as the owner keeps its request asserted.
//  - An optional hold limit forces release so no requester can hog the resource.
//  - Default arbitration is fixed priority, highest index wins (same ordering as the 4:2 priority encoder).

---
 rtl/arb_pkg.sv | 35 +++
 rtl/arb_prio_pick.sv | 47 ++++
 rtl/req_priority_arbiter.sv | 154 +++++++++++++++
 tb/tb_req_priority_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the request/grant arbiter:
// FSM state encoding, the state enum built on it, and width helpers.
package arb_pkg;

  // State encoding of the arbiter FSM.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_GRANT   = ST_GRANT,
    S_RELEASE = ST_RELEASE
  } arb_state_t;

  // Ceiling log2: number of bits needed to encode 'value' distinct codes.
  function automatic int clog2(input int value);
    int v;
    int w;
    v = value - 1;
    w = 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return w;
  endfunction

  // Hold counter width: it only ever counts 0 .. max_hold-1, and is at
  // least one bit wide so the register exists for every configuration.
  function automatic int cnt_width(input int max_hold);
    return (max_hold <= 2) ? 1 : clog2(max_hold);
  endfunction

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational priority pick used by req_priority_arbiter.
// Scans downward from i_start, wrapping from 0 to N-1, and returns the first
// requester that is not masked. With i_start tied to N-1 this is plain fixed
// priority (highest index wins); a moving i_start gives round robin, which
// the top enables with the RR_ARB_EN macro.
module arb_prio_pick import arb_pkg::*; #(
  parameter int N     = 4,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [N-1:0]     i_mask,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_pick,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_elig;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_elig
      assign w_elig[gi] = i_req[gi] & ~i_mask[gi];
    end
  endgenerate

  // Visit candidates farthest-from-start first so the one closest to the
  // start pointer overwrites the others and wins.
  always_comb begin
    logic [IDX_W-1:0] cand_idx;
    cand_idx = '0;
    o_pick   = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int off = N - 1; off >= 0; off--) begin
      cand_idx = IDX_W'((int'(i_start) + N - off) % N);
      if (w_elig[cand_idx]) begin
        o_idx = cand_idx;
        o_any = 1'b1;
      end
    end
    if (o_any) begin
      o_pick[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/req_priority_arbiter.sv
// req_priority_arbiter: shares one resource between N requesters with a
// registered req/gnt handshake.
//  - Requests are registered first; every decision works on that sampled
//    copy, so a request seen at one edge shows up as a grant one edge later,
//    and an owner dropping its request loses the grant one edge later too.
//  - The owner keeps the grant while its request stays high, up to MAX_HOLD
//    consecutive cycles (0 = unlimited). A forced release pulses timeout
//    during the last granted cycle and masks the old owner from the single
//    arbitration that follows.
//  - Every ownership ends with exactly one dead cycle (RELEASE).
//  - Macro RR_ARB_EN: round-robin arbitration instead of fixed priority
//    (highest index wins). Without it the rotating pointer is not built.
module req_priority_arbiter import arb_pkg::*; #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDX_W    = clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             timeout
);

  localparam int              CNT_W     = cnt_width(MAX_HOLD);
  localparam bit              LIMIT_EN  = (MAX_HOLD != 0);
  // Counter value of the final cycle an owner may hold the grant.
  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_t       r_state;
  logic [N-1:0]     r_req;
  logic [N-1:0]     r_mask;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [N-1:0]     r_gnt;
  logic [IDX_W-1:0] r_gnt_idx;
  logic             r_gnt_vld;
  logic             r_timeout;

  logic [N-1:0]     w_pick;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic [IDX_W-1:0] w_start;
  logic             w_new_grant;
  logic             w_owner_req;
  logic             w_owner_req_now;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_limit_hit;

  // Arbitration only runs outside GRANT, so there is never preemption.
  assign w_new_grant     = (r_state != S_GRANT) && w_any;
  // Sampled request of the owner drives decisions; the live request is
  // what the next sample will be, used to time the timeout pulse.
  assign w_owner_req     = r_req[r_gnt_idx];
  assign w_owner_req_now = req[r_gnt_idx];
  assign w_cnt_inc       = r_hold_cnt + 1'b1;
  assign w_limit_hit     = LIMIT_EN && (r_hold_cnt == HOLD_LAST);

`ifdef RR_ARB_EN
  logic [IDX_W-1:0] r_rr_ptr;

  assign w_start = r_rr_ptr;

  // Move the search start just below each new owner, wrapping 0 -> N-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= IDX_W'(N - 1);
    end else if (w_new_grant) begin
      r_rr_ptr <= (w_idx == '0) ? IDX_W'(N - 1) : (w_idx - 1'b1);
    end
  end
`else
  assign w_start = IDX_W'(N - 1);
`endif

  arb_prio_pick #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_pick (
    .i_req   (r_req),
    .i_mask  (r_mask),
    .i_start (w_start),
    .o_pick  (w_pick),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Arbiter FSM with hold counter, release mask and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= '0;
      r_mask     <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_req     <= req;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE, S_RELEASE: begin
          // The mask from a forced release applies to this one arbitration.
          r_mask <= '0;
          if (w_any) begin
            r_state    <= S_GRANT;
            r_gnt      <= w_pick;
            r_gnt_idx  <= w_idx;
            r_gnt_vld  <= 1'b1;
            r_hold_cnt <= '0;
            // With a one-cycle limit the first granted cycle is also the last.
            r_timeout  <= LIMIT_EN && (HOLD_LAST == '0) && req[w_idx];
          end else begin
            r_state   <= S_IDLE;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
          end
        end
        S_GRANT: begin
          if (!w_owner_req) begin
            r_state   <= S_RELEASE;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
          end else if (w_limit_hit) begin
            r_state   <= S_RELEASE;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_mask    <= r_gnt;
          end else begin
            if (LIMIT_EN) begin
              r_hold_cnt <= w_cnt_inc;
              // Pulse during the cycle in which the limit will force release.
              r_timeout  <= (w_cnt_inc == HOLD_LAST) && w_owner_req_now;
            end
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gnt     <= '0;
          r_gnt_vld <= 1'b0;
          r_mask    <= '0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign gnt_vld = r_gnt_vld;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_req_priority_arbiter.sv
// Self-checking bench for req_priority_arbiter (N=4, MAX_HOLD=4).
// A cycle-level reference model tracks the owner, how many cycles it has
// held the grant and which requester is excluded after a timeout; directed
// scenarios are followed by a random request phase. Define RR_ARB_EN for
// both DUT and bench to check the round-robin build.
module tb_req_priority_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_idx;
  logic         gnt_vld;
  logic         timeout;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int           m_owner;     // -1 when nobody owns the resource
  int           m_held;      // granted cycles of the current ownership
  int           m_excl;      // requester excluded from the next arbitration
  int           m_rr;        // round-robin search start
  int           m_last_idx;
  logic [N-1:0] m_prev_req;  // request as seen at the previous edge
  bit           m_to;

  logic [N-1:0] rnd_req;
  logic [N-1:0] nreq;
  bit           prev_vld;
  int           got[$];
  int           exp_order[5];

  req_priority_arbiter #(
    .N        (N),
    .MAX_HOLD (MAXH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic bit bit_at(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // First requester found walking down from 'start' with wrap, skipping excl.
  function automatic int pick_winner(input logic [N-1:0] r, input int excl, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = ((start - k) % N + N) % N;
      if (bit_at(r, c) && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_held     = 0;
    m_excl     = -1;
    m_rr       = N - 1;
    m_last_idx = 0;
    m_prev_req = '0;
    m_to       = 1'b0;
  endtask

  // Advance the model by one clock edge; r_now is the request at that edge.
  task automatic model_edge(input logic [N-1:0] r_now);
    int w;
    int start;
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (!bit_at(m_prev_req, m_owner)) begin
        m_owner = -1;
        m_excl  = -1;
      end else if (m_held == MAXH) begin
        m_excl  = m_owner;
        m_owner = -1;
      end else begin
        m_held = m_held + 1;
        m_to   = (m_held == MAXH) && bit_at(r_now, m_owner);
      end
    end else begin
`ifdef RR_ARB_EN
      start = m_rr;
`else
      start = N - 1;
`endif
      w      = pick_winner(m_prev_req, m_excl, start);
      m_excl = -1;
      if (w >= 0) begin
        m_owner    = w;
        m_held     = 1;
        m_last_idx = w;
        m_to       = (MAXH == 1) && bit_at(r_now, w);
        m_rr       = (w == 0) ? N - 1 : w - 1;
      end
    end
    m_prev_req = r_now;
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    cmp({tag, ".gnt"},     8'(gnt),     8'(eg));
    cmp({tag, ".gnt_vld"}, 8'(gnt_vld), 8'(m_owner >= 0));
    cmp({tag, ".gnt_idx"}, 8'(gnt_idx), 8'(m_last_idx));
    cmp({tag, ".timeout"}, 8'(timeout), 8'(m_to));
  endtask

  // One transaction: drive req, take an edge, check on the falling edge.
  task automatic step(input logic [N-1:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_edge(r);
    @(negedge clk);
    check_model(tag);
    $display("%s t=%0t req=%b gnt=%b idx=%0d vld=%b timeout=%b",
             tag, $time, req, gnt, gnt_idx, gnt_vld, timeout);
  endtask

  // Assert reset in the middle of a cycle and check outputs clear at once.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    cmp({tag, ".rst_gnt"},  8'(gnt),     8'h00);
    cmp({tag, ".rst_vld"},  8'(gnt_vld), 8'h00);
    cmp({tag, ".rst_to"},   8'(timeout), 8'h00);
    cmp({tag, ".rst_idx"},  8'(gnt_idx), 8'h00);
    model_reset();
    @(negedge clk);
    check_model({tag, ".held"});
    $display("%s t=%0t reset applied", tag, $time);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_model("reset");
    rst_n = 1'b1;

    // Fixed priority pick and single dead cycle on drop.
    step(4'b0101, "t2");
    step(4'b0101, "t2");
    cmp("t2.gnt_0100", 8'(gnt), 8'h04);
    cmp("t2.idx_2", 8'(gnt_idx), 8'h02);
    step(4'b0001, "t2");
    step(4'b0001, "t2");
    cmp("t2.dead", 8'(gnt), 8'h00);
    step(4'b0001, "t2");
    cmp("t2.gnt_0001", 8'(gnt), 8'h01);

    // Owner holds, higher request ignored until the owner drops.
    step(4'b1001, "t3");
    cmp("t3.hold", 8'(gnt), 8'h01);
    step(4'b1000, "t3");
    step(4'b1000, "t3");
    cmp("t3.dead", 8'(gnt), 8'h00);
    step(4'b1000, "t3");
    cmp("t3.gnt_1000", 8'(gnt), 8'h08);
    for (int i = 0; i < 4; i++) step(4'b0000, "idle");

    // Hold limit with a competing requester.
    step(4'b1010, "t4");
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, "t4");
      cmp("t4.gnt_1000", 8'(gnt), 8'h08);
      cmp("t4.timeout", 8'(timeout), (i == 3) ? 8'h01 : 8'h00);
    end
    step(4'b1010, "t4");
    cmp("t4.dead", 8'(gnt), 8'h00);
    step(4'b1010, "t4");
    cmp("t4.gnt_0010", 8'(gnt), 8'h02);
    for (int i = 0; i < 4; i++) step(4'b0000, "idle");

    // Lone hog: two dead cycles before it is granted again.
    step(4'b0001, "t5");
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, "t5");
      cmp("t5.gnt_0001", 8'(gnt), 8'h01);
    end
    step(4'b0001, "t5");
    cmp("t5.dead1", 8'(gnt), 8'h00);
    step(4'b0001, "t5");
    cmp("t5.dead2", 8'(gnt), 8'h00);
    step(4'b0001, "t5");
    cmp("t5.regrant", 8'(gnt), 8'h01);
    for (int i = 0; i < 4; i++) step(4'b0000, "idle");

    // All request; each new owner drops its request for one sample.
`ifdef RR_ARB_EN
    exp_order = '{3, 2, 1, 0, 3};
`else
    exp_order = '{3, 3, 3, 3, 3};
`endif
    prev_vld = gnt_vld;
    nreq     = '1;
    for (int i = 0; i < 60 && got.size() < 5; i++) begin
      step(nreq, "t6");
      if (gnt_vld && !prev_vld) begin
        got.push_back(int'(gnt_idx));
        nreq = '1 & ~gnt;
      end else begin
        nreq = '1;
      end
      prev_vld = gnt_vld;
    end
    cmp("t6.count", 8'(got.size()), 8'd5);
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      cmp("t6.order", 8'(got[k]), 8'(exp_order[k]));
    end
    for (int i = 0; i < 4; i++) step(4'b0000, "idle");

    // Reset in the middle of a grant.
    step(4'b0100, "t1");
    step(4'b0100, "t1");
    step(4'b0100, "t1");
    cmp("t1.gnt_0100", 8'(gnt), 8'h04);
    async_reset("t1");
    step(4'b0001, "t1");
    cmp("t1.wait", 8'(gnt), 8'h00);
    step(4'b0001, "t1");
    cmp("t1.gnt_0001", 8'(gnt), 8'h01);

    // Random requests, mostly slowly changing so ownerships run long.
    rnd_req = '0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) rnd_req[b] = ~rnd_req[b];
      end
      if ($urandom_range(49) == 0) rnd_req = '1;
      step(rnd_req, "rand");
      if (i == 200) async_reset("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
